// File: rtl/gcd_pkg.sv
// Shared encodings for the GCD controller, datapath and ALU: ALU opcodes,
// controller state encoding and the per-state strobe decode.
package gcd_pkg;

  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_MAX = 3'd1;
  localparam logic [2:0] ALU_MIN = 3'd2;
  localparam logic [2:0] ALU_MOD = 3'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_MAX_OP,
    S_MAX_WB,
    S_MIN_OP,
    S_MIN_WB,
    S_ORDER,
    S_MOD_START,
    S_MOD_WAIT,
    S_MOD_WB,
    S_CHECK,
    S_SHIFT,
    S_NEXT,
    S_DONE,
    S_FAIL
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       dp_start;
    logic [2:0] alu_mode;
    logic       modulo_start;
    logic       wren_zw_gross;
    logic       wren_zw_klein;
    logic       wren_zw_in_zahlen;
    logic       wren_erg_modulo;
    logic       wren_zahl;
    logic       wren_to_new_numbers;
    logic       zahl1_to_alu_a;
    logic       zahl2_to_alu_b;
    logic       check_for_termination;
  } ctrl_t;

  // Moore strobe pattern for each state; at most one write enable per state.
  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != S_IDLE);
    case (s)
      S_LOAD:      c.dp_start = 1'b1;
      S_MAX_OP: begin
        c.alu_mode       = ALU_MAX;
        c.zahl1_to_alu_a = 1'b1;
        c.zahl2_to_alu_b = 1'b1;
      end
      S_MAX_WB:    c.wren_zw_gross = 1'b1;
      S_MIN_OP: begin
        c.alu_mode       = ALU_MIN;
        c.zahl1_to_alu_a = 1'b1;
        c.zahl2_to_alu_b = 1'b1;
      end
      S_MIN_WB:    c.wren_zw_klein = 1'b1;
      S_ORDER:     c.wren_zw_in_zahlen = 1'b1;
      S_MOD_START: begin
        c.alu_mode       = ALU_MOD;
        c.zahl1_to_alu_a = 1'b1;
        c.zahl2_to_alu_b = 1'b1;
        c.modulo_start   = 1'b1;
      end
      S_MOD_WAIT: begin
        c.alu_mode       = ALU_MOD;
        c.zahl1_to_alu_a = 1'b1;
        c.zahl2_to_alu_b = 1'b1;
      end
      S_MOD_WB:    c.wren_erg_modulo = 1'b1;
      S_CHECK:     c.check_for_termination = 1'b1;
      S_SHIFT:     c.wren_zahl = 1'b1;
      S_NEXT:      c.wren_to_new_numbers = 1'b1;
      S_DONE:      c.done = 1'b1;
      S_FAIL: begin
        c.done = 1'b1;
        c.err  = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gcd_ctrl_if.sv
// Request/strobe bundle between the GCD controller (slave) and the
// request side plus datapath that drive and consume it (master).
interface gcd_ctrl_if;
  logic       start;
  logic       modulo_ready;
  logic       valid;
  logic       busy;
  logic       done;
  logic       err;
  logic       dp_start;
  logic [2:0] alu_mode;
  logic       modulo_start;
  logic       wren_zw_gross;
  logic       wren_zw_klein;
  logic       wren_zw_in_zahlen;
  logic       wren_erg_modulo;
  logic       wren_zahl;
  logic       wren_to_new_numbers;
  logic       zahl1_to_alu_a;
  logic       zahl2_to_alu_b;
  logic       check_for_termination;

  modport master (
    output start, modulo_ready, valid,
    input  busy, done, err, dp_start, alu_mode, modulo_start,
           wren_zw_gross, wren_zw_klein, wren_zw_in_zahlen, wren_erg_modulo,
           wren_zahl, wren_to_new_numbers, zahl1_to_alu_a, zahl2_to_alu_b,
           check_for_termination
  );

  modport slave (
    input  start, modulo_ready, valid,
    output busy, done, err, dp_start, alu_mode, modulo_start,
           wren_zw_gross, wren_zw_klein, wren_zw_in_zahlen, wren_erg_modulo,
           wren_zahl, wren_to_new_numbers, zahl1_to_alu_a, zahl2_to_alu_b,
           check_for_termination
  );
endinterface

// File: rtl/gcd_ctrl.sv
// Sequencing FSM for the 16-bit Euclidean GCD datapath: walks max/min
// ordering, then modulo iterations until the remainder is zero or a limit hits.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int MOD_TIMEOUT = 64,
  parameter int MAX_ITER    = 32
) (
  input  logic       clk,
  input  logic       rst,
  gcd_ctrl_if.slave  bus
);

  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam int TMO_W  = (MOD_TIMEOUT > 1) ? $clog2(MOD_TIMEOUT) : 1;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(MOD_TIMEOUT - 1);

  state_t              state;
  state_t              nxt;
  ctrl_t               outs;
  logic [ITER_W-1:0]   iter_cnt;
  logic [TMO_W-1:0]    tmo_cnt;

  // NOTE: nxt gets a default before the case so no path leaves it unassigned
  // (otherwise a latch is inferred).
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:      if (bus.start) nxt = S_LOAD;
      S_LOAD:      nxt = S_MAX_OP;
      S_MAX_OP:    nxt = S_MAX_WB;
      S_MAX_WB:    nxt = S_MIN_OP;
      S_MIN_OP:    nxt = S_MIN_WB;
      S_MIN_WB:    nxt = S_ORDER;
      S_ORDER:     nxt = S_MOD_START;
      S_MOD_START: nxt = S_MOD_WAIT;
      S_MOD_WAIT: begin
        // A ready arriving together with the last timeout cycle still wins.
        if (bus.modulo_ready)       nxt = S_MOD_WB;
        else if (tmo_cnt == TMO_LAST) nxt = S_FAIL;
      end
      S_MOD_WB:    nxt = S_CHECK;
      S_CHECK: begin
        if (bus.valid)                  nxt = S_DONE;
        else if (iter_cnt == ITER_LAST) nxt = S_FAIL;
        else                            nxt = S_SHIFT;
      end
      S_SHIFT:     nxt = S_NEXT;
      S_NEXT:      nxt = S_MOD_START;
      S_DONE:      nxt = S_IDLE;
      S_FAIL:      nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      outs     <= '0;
      iter_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state <= nxt;
      outs  <= decode(nxt);
      case (state)
        S_ORDER:     iter_cnt <= '0;
        S_MOD_START: begin
          if (iter_cnt != ITER_LAST) iter_cnt <= iter_cnt + 1'b1;
          tmo_cnt <= '0;
        end
        S_MOD_WAIT:  if (nxt == S_MOD_WAIT && tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy                  = outs.busy;
  assign bus.done                  = outs.done;
  assign bus.err                   = outs.err;
  assign bus.dp_start              = outs.dp_start;
  assign bus.alu_mode              = outs.alu_mode;
  assign bus.modulo_start          = outs.modulo_start;
  assign bus.wren_zw_gross         = outs.wren_zw_gross;
  assign bus.wren_zw_klein         = outs.wren_zw_klein;
  assign bus.wren_zw_in_zahlen     = outs.wren_zw_in_zahlen;
  assign bus.wren_erg_modulo       = outs.wren_erg_modulo;
  assign bus.wren_zahl             = outs.wren_zahl;
  assign bus.wren_to_new_numbers   = outs.wren_to_new_numbers;
  assign bus.zahl1_to_alu_a        = outs.zahl1_to_alu_a;
  assign bus.zahl2_to_alu_b        = outs.zahl2_to_alu_b;
  assign bus.check_for_termination = outs.check_for_termination;

endmodule
